// File: rtl/id_token_stat_pkg.sv
// Shared definitions for the identifier pipeline: ASCII class bounds and the
// character-class enum used by the recognizer FSM and its statistics consumer.
package id_token_stat_pkg;

  localparam logic [7:0] CH_DIG_LO = 8'h30;  // '0'
  localparam logic [7:0] CH_DIG_HI = 8'h39;  // '9'
  localparam logic [7:0] CH_UP_LO  = 8'h41;  // 'A'
  localparam logic [7:0] CH_UP_HI  = 8'h5A;  // 'Z'
  localparam logic [7:0] CH_LO_LO  = 8'h61;  // 'a'
  localparam logic [7:0] CH_LO_HI  = 8'h7A;  // 'z'

  typedef enum logic [1:0] {
    CLS_ALPHA = 2'd0,
    CLS_DIGIT = 2'd1,
    CLS_OTHER = 2'd2
  } char_cls_e;

endpackage

// File: rtl/id_token_stat_char_class.sv
// Combinational ASCII classifier: letter, digit, or terminator.
module id_token_stat_char_class
  import id_token_stat_pkg::*;
(
  input  logic [7:0] ch,
  output char_cls_e  cls
);

  // Range decode; anything outside the alnum ranges is a terminator
  always_comb begin
    cls = CLS_OTHER;
    if (ch >= CH_DIG_LO && ch <= CH_DIG_HI) begin
      cls = CLS_DIGIT;
    end else if ((ch >= CH_UP_LO && ch <= CH_UP_HI) ||
                 (ch >= CH_LO_LO && ch <= CH_LO_HI)) begin
      cls = CLS_ALPHA;
    end
  end

endmodule

// File: rtl/id_token_stat.sv
// Identifier token statistics. Realigns the byte stream with the recognizer's
// registered match flag, reports each completed token and keeps saturating
// running statistics (count, longest token, current alnum run).
module id_token_stat
  import id_token_stat_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       char,
  input  logic             match_in,
  input  logic             clr,
  output logic             tok_done,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] tok_cnt,
  output logic [LEN_W-1:0] max_len,
  output logic [LEN_W-1:0] run_len,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [LEN_W-1:0] LenMax = '1;

  // char_d lines up with the FSM's view one edge later; m_d holds the match
  // state as it stood before char_d, i.e. at the end of the run
  logic [7:0] char_d;
  logic       m_d;
  char_cls_e  cls;
  logic       is_alnum;
  logic       run_full;
  logic       cnt_full;
  logic       tok_end;

  id_token_stat_char_class u_char_class (
    .ch  (char_d),
    .cls (cls)
  );

  assign is_alnum = (cls != CLS_OTHER);
  assign run_full = (run_len == LenMax);
  assign cnt_full = (tok_cnt == CntMax);
  assign tok_end  = !is_alnum && m_d;

  // Alignment registers, free-running regardless of clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_d <= 8'h00;
      m_d    <= 1'b0;
    end else begin
      char_d <= char;
      m_d    <= match_in;
    end
  end

  // Current alnum run length, saturating; clr does not touch a run in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len <= '0;
    end else if (is_alnum) begin
      if (!run_full) run_len <= run_len + 1'b1;
    end else begin
      run_len <= '0;
    end
  end

  // Token completion and statistics; clr wins over a simultaneous completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_done <= 1'b0;
      tok_len  <= '0;
      tok_cnt  <= '0;
      max_len  <= '0;
      cnt_sat  <= 1'b0;
    end else if (clr) begin
      tok_done <= 1'b0;
      tok_len  <= '0;
      tok_cnt  <= '0;
      max_len  <= '0;
      cnt_sat  <= 1'b0;
    end else begin
      tok_done <= tok_end;
      if (tok_end) begin
        tok_len <= run_len;
        if (!cnt_full) tok_cnt <= tok_cnt + 1'b1;
        if (run_len > max_len) max_len <= run_len;
      end
      // Sticky once any counter has to clamp
      if ((is_alnum && run_full) || (tok_end && cnt_full)) cnt_sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_token_stat.sv
// Bench for id_token_stat: an upstream-FSM model drives match_in, a reference
// model pushes expected token reports into a queue, a monitor pops on tok_done.
module tb_id_token_stat;

  localparam int CntW   = 16;
  localparam int LenW   = 8;
  localparam int LenMax = 255;
  localparam int CntMax = 65535;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      char;
  logic            match_in;
  logic            clr;
  logic            tok_done;
  logic [LenW-1:0] tok_len;
  logic [CntW-1:0] tok_cnt;
  logic [LenW-1:0] max_len;
  logic [LenW-1:0] run_len;
  logic            cnt_sat;

  id_token_stat #(
    .CNT_W (CntW),
    .LEN_W (LenW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .char     (char),
    .match_in (match_in),
    .clr      (clr),
    .tok_done (tok_done),
    .tok_len  (tok_len),
    .tok_cnt  (tok_cnt),
    .max_len  (max_len),
    .run_len  (run_len),
    .cnt_sat  (cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int cnt;
    int mx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: the run as seen by the stream, plus pending events that
  // the DUT will act on one edge after the character is sampled
  int m_run, m_cnt, m_max, pend_len;
  bit has_alpha, last_digit, pend_tok, pend_sat, m_sat;
  bit prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_alpha(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic bit is_digit(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  function automatic int min_len(input int v);
    return (v > LenMax) ? LenMax : v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_max = 0; pend_len = 0;
    has_alpha = 0; last_digit = 0; pend_tok = 0; pend_sat = 0; m_sat = 0;
    q.delete();
  endtask

  // Drive one character for one edge and check the state after that edge
  task automatic step(input logic [7:0] c, input logic clr_v);
    bit nm;
    bit exp_done;
    int exp_run;
    char = c;
    clr  = clr_v;
    exp_run  = min_len(m_run);
    exp_done = 1'b0;
    if (clr_v) begin
      m_cnt = 0; m_max = 0; m_sat = 0;
    end else begin
      if (pend_sat) m_sat = 1;
      if (pend_tok) begin
        if (m_cnt == CntMax) m_sat = 1;
        else m_cnt++;
        if (pend_len > m_max) m_max = pend_len;
        q.push_back('{len: pend_len, cnt: m_cnt, mx: m_max});
        exp_done = 1'b1;
      end
    end
    pend_tok = 0;
    pend_sat = 0;
    if (is_alpha(c) || is_digit(c)) begin
      if (m_run >= LenMax) pend_sat = 1;
      m_run++;
      if (is_alpha(c)) has_alpha = 1;
      last_digit = is_digit(c);
    end else begin
      if (m_run > 0 && has_alpha && last_digit) begin
        pend_tok = 1;
        pend_len = min_len(m_run);
      end
      m_run = 0; has_alpha = 0; last_digit = 0;
    end
    nm = (m_run > 0) && has_alpha && last_digit;
    @(posedge clk);
    #1;
    match_in = nm;
    chk("run_len", int'(run_len), exp_run);
    chk("tok_done", int'(tok_done), int'(exp_done));
    chk("tok_cnt", int'(tok_cnt), m_cnt);
    chk("max_len", int'(max_len), m_max);
    chk("cnt_sat", int'(cnt_sat), int'(m_sat));
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tok_done"}, int'(tok_done), 0);
    chk({tag, "_tok_len"}, int'(tok_len), 0);
    chk({tag, "_tok_cnt"}, int'(tok_cnt), 0);
    chk({tag, "_max_len"}, int'(max_len), 0);
    chk({tag, "_run_len"}, int'(run_len), 0);
    chk({tag, "_cnt_sat"}, int'(cnt_sat), 0);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    match_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: every tok_done pulse must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && tok_done) begin
      chk("pulse_not_adjacent", int'(prev_done), 0);
      chk("pulse_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mon_tok_len", int'(tok_len), e.len);
        chk("mon_tok_cnt", int'(tok_cnt), e.cnt);
        chk("mon_max_len", int'(max_len), e.mx);
      end
    end
    prev_done = rst_n && tok_done;
  end

  initial begin
    string punct = ",;.-!";
    int    r;
    logic [7:0] c;
    rst_n = 1'b0; char = 8'h00; clr = 1'b0; match_in = 1'b0;
    model_reset();
    #12 check_zero("reset");
    #5 rst_n = 1'b1;

    // Single token, 2-edge latency after the space
    send("ab12 ");
    chk("ab12_no_early_done", int'(tok_done), 0);
    step(" ", 1'b0);
    chk("ab12_done", int'(tok_done), 1);
    chk("ab12_len", int'(tok_len), 4);
    chk("ab12_cnt", int'(tok_cnt), 1);
    chk("ab12_max", int'(max_len), 4);

    // Non-tokens
    send("12 ");
    chk("digits_run", int'(run_len), 2);
    step(" ", 1'b0);
    chk("digits_run_clear", int'(run_len), 0);
    send("a1b ");
    chk("a1b_run", int'(run_len), 3);
    step(" ", 1'b0);
    chk("a1b_run_clear", int'(run_len), 0);
    chk("nontok_cnt", int'(tok_cnt), 1);

    // Three tokens back to back
    send("x9,y77;q1 ");
    step(" ", 1'b0);
    chk("three_last_len", int'(tok_len), 2);
    chk("three_cnt", int'(tok_cnt), 4);
    chk("three_max", int'(max_len), 4);
    step(" ", 1'b1);

    // clr on the completion edge drops the token; the next one counts
    send("k7 ");
    step("m", 1'b1);
    chk("clr_drop_done", int'(tok_done), 0);
    chk("clr_drop_cnt", int'(tok_cnt), 0);
    send("3 ");
    step(" ", 1'b0);
    chk("after_clr_cnt", int'(tok_cnt), 1);
    chk("after_clr_len", int'(tok_len), 2);

    // Run saturation
    for (int i = 0; i < 300; i++) step("a", 1'b0);
    chk("sat_run", int'(run_len), LenMax);
    chk("sat_flag", int'(cnt_sat), 1);
    send("5 ");
    step(" ", 1'b0);
    chk("sat_tok_len", int'(tok_len), LenMax);
    send("   ");
    chk("sat_sticky", int'(cnt_sat), 1);
    step(" ", 1'b1);
    chk("sat_cleared", int'(cnt_sat), 0);

    // Reset in the middle of a would-be token
    send("abc12");
    pulse_reset();
    send("3 ");
    step(" ", 1'b0);
    chk("rst_no_token", int'(tok_cnt), 0);
    send("z1 ");
    step(" ", 1'b0);
    chk("rst_next_token", int'(tok_cnt), 1);

    // Randomised stream with occasional clr
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      c = 8'(($urandom_range(0, 1) != 0 ? 65 : 97) + $urandom_range(0, 25));
      else if (r <= 6) c = 8'(48 + $urandom_range(0, 9));
      else if (r == 7) c = " ";
      else if (r == 8) c = punct[$urandom_range(0, 4)];
      else             c = 8'($urandom_range(0, 255));
      step(c, ($urandom_range(0, 24) == 0));
    end
    send("   ");
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_token_stat.md
Name: id_token_stat

Overview:
- Downstream consumer of the identifier-recognizer FSM in the character-stream pipeline.
- Receives the same byte stream as the FSM (one character per clk) plus the FSM's registered match flag, and realigns the two internally.
- Detects completed identifier tokens, reports each token's length, and keeps running statistics: token count, longest token, current alphanumeric run.
- Results go to a status register / display stage.

Parameters:
- CNT_W, 16: width of the token counter; saturating.
- LEN_W, 8: width of the run and token length fields; saturating.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- char  in  8  ASCII character; the same byte the FSM samples on the same edge, one per cycle, no valid qualifier.
- match_in  in  1  FSM output; after edge k it reflects the FSM state after char_k.
- clr  in  1  synchronous clear of statistics.
- tok_done  out  1  one-cycle pulse; a token has just completed.
- tok_len  out  LEN_W  length of the most recently completed token; held between tokens.
- tok_cnt  out  CNT_W  number of completed tokens; saturating.
- max_len  out  LEN_W  largest tok_len since reset or clr.
- run_len  out  LEN_W  length of the current alphanumeric run.
- cnt_sat  out  1  sticky flag; tok_cnt or any length field has saturated.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0. Internal char_d=8'h00 and m_d=0.
- Character classes:
  - alpha = 8'h41..8'h5A or 8'h61..8'h7A.
  - digit = 8'h30..8'h39.
  - alnum = alpha or digit.
  - Any other byte is a terminator.
- Alignment registers, updated every edge: char_d <= char; m_d <= match_in.
- At edge k+1, the processing step uses char_d = char_k, match_in = match after char_k, and m_d = match after char_(k-1).
- Processing at each edge, when clr=0:
  - char_d is alnum: run_len <= min(run_len+1, 2^LEN_W-1). Set cnt_sat if the increment saturates.
  - char_d is a terminator and m_d=1 (token complete):
    - tok_done <= 1 and tok_len <= run_len.
    - tok_cnt <= min(tok_cnt+1, 2^CNT_W-1); set cnt_sat on saturation.
    - max_len <= max(max_len, run_len).
    - run_len <= 0.
  - char_d is a terminator and m_d=0: run_len <= 0; tok_done <= 0; no statistics change.
  - tok_done is 0 in every other cycle; it is never high two cycles in a row.
- Token definition: a maximal alnum run whose last char is a digit and which contains at least one letter; this is exactly when m_d=1 at the terminator. Runs ending in a letter and digit-only runs are not tokens.
- Latency: a terminator sampled at edge k gives tok_done high in the cycle after edge k+1 (2 edges). tok_len, tok_cnt and max_len update on that same edge.
- clr=1 (synchronous):
  - tok_cnt, max_len, tok_len and cnt_sat go to 0, and tok_done is 0; clr wins over a simultaneous token completion, which is dropped.
  - run_len and the alignment registers keep operating normally, so a run in progress continues counting.
- Reset mid-token: the partial run is discarded.
- After reset release, the first processed char_d is 8'h00, a terminator with m_d=0, so no spurious token.
- Saturated values hold until clr or reset. A saturated run still completes as a token with tok_len = 2^LEN_W-1.

Decomposition:
- Shared package:
  - ASCII bound constants: CH_DIG_LO/HI, CH_UP_LO/HI, CH_LO_LO/HI.
  - Character-class enum: CLS_ALPHA, CLS_DIGIT, CLS_OTHER.
- Sub-module char_class: combinational, 8-bit in, class out. The same FSM neighbour can reuse it.
- Core: alignment registers, saturating counters and the max comparator.

Test Plan:
- Stream "ab12 " with the FSM model driving match_in -> exactly one tok_done pulse, 2 edges after the space; tok_len=4, tok_cnt=1, max_len=4.
- Streams "12 " and "a1b " -> no tok_done; tok_cnt stays 0; run_len reaches 2 then 3, then returns to 0 after the terminator.
- Stream "x9,y77;q1 " -> three pulses, tok_len 2, 3, 2 in order; tok_cnt=3; max_len=3; pulses are never adjacent.
- 300 consecutive 'a' followed by "5 " (LEN_W=8) -> run_len sticks at 255; tok_len=255; cnt_sat=1 and stays 1 until clr.
- clr asserted on the same edge as the tok_done for "k7 " -> tok_cnt=0, tok_done=0. The next token "m3 " -> tok_cnt=1, tok_len=2.
- rst_n pulsed low asynchronously, between edges, mid-way through "abc12", then stream resumes with "3 " -> outputs go to 0 immediately; "3 " gives no token; subsequent "z1 " -> tok_cnt=1.
